// File: rtl/uart_burst_bridge.sv
// UART host command bridge: single/burst bus read/write with auto-increment, CPU halt control,
// inter-byte timeout and a one-entry receive skid. Define UART_BRIDGE_ACK_EN to send 0xA5 after writes.
module uart_burst_bridge #(
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 2_500_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_active,
  input  logic              tx_done,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  input  logic              bus_gnt,
  input  logic [7:0]        bus_rdata,
  output logic              cpu_halt,
  output logic              err_overrun,
  output logic              busy
);
  localparam int ADDR_B = (ADDR_W + 7) / 8;
  localparam int AB_W   = (ADDR_B > 1) ? $clog2(ADDR_B) : 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, LEN, WDATA, BUS_WR, BUS_RD, TX_START, TX_WAIT
`ifdef UART_BRIDGE_ACK_EN
    , ACK
`endif
  } state_t;

  state_t              state, state_n;
  logic                skid_full;
  logic [7:0]          skid_data;
  logic [ADDR_W-1:0]   addr;
  logic [7:0]          wdata, rhold;
  logic [8:0]          cnt;
  logic [AB_W-1:0]     abyte;
  logic                is_wr, is_burst;
  logic [TO_W-1:0]     to_cnt;
  logic                in_cmd, rx_state, expire, take, tx_fire, last_beat;
  logic [7:0]          byte_in;
  logic [ADDR_W+7:0]   ash;

  assign in_cmd    = (state == ADDR) || (state == LEN) || (state == WDATA);
  assign rx_state  = in_cmd || (state == IDLE);
  // An empty skid is required so an expiry can never discard a byte that was already accepted.
  assign expire    = in_cmd && !skid_full && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign take      = rx_state && !expire && (skid_full || rx_valid);
  assign byte_in   = skid_full ? skid_data : rx_data;
  assign ash       = {addr, byte_in};
  assign last_beat = (cnt == 9'd1);
`ifdef UART_BRIDGE_ACK_EN
  assign tx_fire   = ((state == TX_START) || (state == ACK)) && !tx_active;
`else
  assign tx_fire   = (state == TX_START) && !tx_active;
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (take && byte_in inside {8'h02, 8'h03, 8'h04, 8'h05}) state_n = ADDR;
      ADDR:     if (expire) state_n = IDLE;
                else if (take && abyte == AB_W'(ADDR_B - 1))
                  state_n = is_burst ? LEN : (is_wr ? WDATA : BUS_RD);
      LEN:      if (expire) state_n = IDLE;
                else if (take) state_n = is_wr ? WDATA : BUS_RD;
      WDATA:    if (expire) state_n = IDLE;
                else if (take) state_n = BUS_WR;
      BUS_WR:   if (bus_gnt) begin
                  if (!last_beat) state_n = WDATA;
`ifdef UART_BRIDGE_ACK_EN
                  else state_n = ACK;
`else
                  else state_n = IDLE;
`endif
                end
      BUS_RD:   if (bus_gnt) state_n = TX_START;
      TX_START: if (!tx_active) state_n = TX_WAIT;
      TX_WAIT:  if (tx_done) state_n = (cnt == 9'd0) ? IDLE : BUS_RD;
`ifdef UART_BRIDGE_ACK_EN
      ACK:      if (!tx_active) state_n = TX_WAIT;
`endif
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      skid_full   <= 1'b0;
      skid_data   <= '0;
      err_overrun <= 1'b0;
      cpu_halt    <= 1'b1;
      addr        <= '0;
      wdata       <= '0;
      rhold       <= '0;
      cnt         <= '0;
      abyte       <= '0;
      is_wr       <= 1'b0;
      is_burst    <= 1'b0;
      to_cnt      <= '0;
      tx_start    <= 1'b0;
    end else begin
      state    <= state_n;
      tx_start <= tx_fire;

      // Skid: drains in decode states, fills while the bus or transmitter owns the FSM.
      if (rx_state) begin
        if (skid_full) begin
          if (rx_valid) skid_data <= rx_data;
          else          skid_full <= 1'b0;
        end else if (rx_valid && expire) begin
          skid_full <= 1'b1;
          skid_data <= rx_data;
        end
      end else if (rx_valid) begin
        if (skid_full) err_overrun <= 1'b1;
        else begin
          skid_full <= 1'b1;
          skid_data <= rx_data;
        end
      end

      if (!in_cmd || take) to_cnt <= '0;
      else                 to_cnt <= to_cnt + 1'b1;

      if (take) begin
        case (state)
          IDLE: begin
            abyte    <= '0;
            cnt      <= 9'd1;
            is_wr    <= (byte_in == 8'h02) || (byte_in == 8'h04);
            is_burst <= (byte_in == 8'h04) || (byte_in == 8'h05);
            if (byte_in == 8'h06) cpu_halt <= 1'b1;
            if (byte_in == 8'h07) cpu_halt <= 1'b0;
          end
          ADDR: begin
            addr  <= ash[ADDR_W-1:0];
            abyte <= abyte + 1'b1;
          end
          LEN:     cnt   <= (byte_in == 8'h00) ? 9'd256 : {1'b0, byte_in};
          WDATA:   wdata <= byte_in;
          default: ;
        endcase
      end

      if (bus_gnt && (state == BUS_WR || state == BUS_RD)) begin
        addr <= addr + 1'b1;
        cnt  <= cnt - 1'b1;
        if (state == BUS_RD) rhold <= bus_rdata;
`ifdef UART_BRIDGE_ACK_EN
        if (state == BUS_WR && last_beat) rhold <= 8'hA5;
`endif
      end
    end
  end

  assign bus_req   = rst && ((state == BUS_WR) || (state == BUS_RD));
  assign bus_we    = (state == BUS_WR);
  assign bus_addr  = addr;
  assign bus_wdata = wdata;
  assign tx_data   = rhold;
  assign busy      = (state != IDLE);
endmodule
